pipe_stall_ctrl: RTL and testbench

//  Hazard and stall controller that sequences the F/D and D/E pipeline registers of the 5-stage core.

---
 rtl/pipe_stall_ctrl_if.sv | 36 +++
 rtl/pipe_stall_ctrl.sv | 76 +++++++
 tb/tb_pipe_stall_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/stall control bundle between the pipeline datapath and the stall controller.
// The datapath (master) presents D/E/M stage hazard info; the controller (slave)
// returns PC/F-D enables, the D/E bubble request and MDU/perf status.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       D_rs;
    logic [4:0]       D_rt;
    logic [1:0]       D_tuse_rs;
    logic [1:0]       D_tuse_rt;
    logic             D_is_md;
    logic [4:0]       E_wr;
    logic [1:0]       E_tnew;
    logic [4:0]       M_wr;
    logic [1:0]       M_tnew;
    logic             E_md_start;
    logic             E_md_is_div;
    logic             pc_en;
    logic             fd_en;
    logic             de_flush;
    logic             md_busy;
    logic [3:0]       md_left;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
        output E_wr, E_tnew, M_wr, M_tnew, E_md_start, E_md_is_div,
        input  pc_en, fd_en, de_flush, md_busy, md_left, stall_count
    );

    modport slave (
        input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
        input  E_wr, E_tnew, M_wr, M_tnew, E_md_start, E_md_is_div,
        output pc_en, fd_en, de_flush, md_busy, md_left, stall_count
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Hazard and stall controller for the 5-stage core.
// Register hazards compare D-stage Tuse against E/M Tnew combinationally; the
// MDU busy window is a registered down-counter. A saturating counter tallies
// stall cycles for performance monitoring.
module pipe_stall_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    pipe_stall_ctrl_if.slave  bus
);

    logic [3:0]       md_left_d;
    logic [3:0]       md_left_q;
    logic [CNT_W-1:0] stall_count_d;
    logic [CNT_W-1:0] stall_count_q;
    logic             md_busy;
    logic             stall_rs;
    logic             stall_rt;
    logic             stall_md;
    logic             stall;

    assign md_busy = (md_left_q != 4'd0);

    // Detect operand and MDU hazards for the instruction sitting in D.
    always_comb begin
        stall_rs = 1'b0;
        stall_rt = 1'b0;
        stall_md = 1'b0;
        if (bus.D_rs != 5'd0) begin
            stall_rs = ((bus.D_rs == bus.E_wr) && (bus.E_tnew > bus.D_tuse_rs)) ||
                       ((bus.D_rs == bus.M_wr) && (bus.M_tnew > bus.D_tuse_rs));
        end
        if (bus.D_rt != 5'd0) begin
            stall_rt = ((bus.D_rt == bus.E_wr) && (bus.E_tnew > bus.D_tuse_rt)) ||
                       ((bus.D_rt == bus.M_wr) && (bus.M_tnew > bus.D_tuse_rt));
        end
        stall_md = bus.D_is_md && (md_busy || bus.E_md_start);
        stall    = stall_rs | stall_rt | stall_md;
    end

    // Compute next MDU countdown and next saturating stall-cycle count.
    always_comb begin
        md_left_d     = md_left_q;
        stall_count_d = stall_count_q;
        if (bus.E_md_start) begin
            md_left_d = bus.E_md_is_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
        end else if (md_left_q != 4'd0) begin
            md_left_d = md_left_q - 4'd1;
        end
        if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Register the MDU countdown and stall counter, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_left_q     <= 4'd0;
            stall_count_q <= '0;
        end else begin
            md_left_q     <= md_left_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.pc_en       = ~stall;
    assign bus.fd_en       = ~stall;
    assign bus.de_flush    = stall;
    assign bus.md_busy     = md_busy;
    assign bus.md_left     = md_left_q;
    assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed testbench for pipe_stall_ctrl. A second instance with a 4-bit stall
// counter shares the same stimulus so saturation can be reached quickly.
module tb_pipe_stall_ctrl;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    pipe_stall_ctrl_if #(.CNT_W(32)) bus ();
    pipe_stall_ctrl_if #(.CNT_W(4))  bus4 ();

    pipe_stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pipe_stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    assign bus4.D_rs        = bus.D_rs;
    assign bus4.D_rt        = bus.D_rt;
    assign bus4.D_tuse_rs   = bus.D_tuse_rs;
    assign bus4.D_tuse_rt   = bus.D_tuse_rt;
    assign bus4.D_is_md     = bus.D_is_md;
    assign bus4.E_wr        = bus.E_wr;
    assign bus4.E_tnew      = bus.E_tnew;
    assign bus4.M_wr        = bus.M_wr;
    assign bus4.M_tnew      = bus.M_tnew;
    assign bus4.E_md_start  = bus.E_md_start;
    assign bus4.E_md_is_div = bus.E_md_is_div;

    // Free-running 10ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.D_rs        = 5'd0;
        bus.D_rt        = 5'd0;
        bus.D_tuse_rs   = 2'd3;
        bus.D_tuse_rt   = 2'd3;
        bus.D_is_md     = 1'b0;
        bus.E_wr        = 5'd0;
        bus.E_tnew      = 2'd0;
        bus.M_wr        = 5'd0;
        bus.M_tnew      = 2'd0;
        bus.E_md_start  = 1'b0;
        bus.E_md_is_div = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (bus.md_left !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_md_left: got %0d expected 0", bus.md_left);
        end
        checks++;
        if (bus.md_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_md_busy: got %0b expected 0", bus.md_busy);
        end
        checks++;
        if (bus.stall_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_stall_count: got %0d expected 0", bus.stall_count);
        end
        checks++;
        if ({bus.pc_en, bus.fd_en, bus.de_flush} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL reset_enables: got %b expected 110",
                     {bus.pc_en, bus.fd_en, bus.de_flush});
        end
    endtask

    task automatic test_lw_use();
        do_reset();
        bus.E_wr = 5'd8; bus.E_tnew = 2'd2; bus.D_rs = 5'd8; bus.D_tuse_rs = 2'd0;
        #1;
        checks++;
        if ({bus.pc_en, bus.fd_en, bus.de_flush} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL lw_use_e_stall: got %b expected 001",
                     {bus.pc_en, bus.fd_en, bus.de_flush});
        end
        tick();
        bus.E_wr = 5'd0; bus.E_tnew = 2'd0; bus.M_wr = 5'd8; bus.M_tnew = 2'd1;
        #1;
        checks++;
        if ({bus.pc_en, bus.fd_en, bus.de_flush} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL lw_use_m_stall: got %b expected 001",
                     {bus.pc_en, bus.fd_en, bus.de_flush});
        end
        tick();
        bus.M_tnew = 2'd0;
        #1;
        checks++;
        if ({bus.pc_en, bus.fd_en, bus.de_flush} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL lw_use_release: got %b expected 110",
                     {bus.pc_en, bus.fd_en, bus.de_flush});
        end
        checks++;
        if (bus.stall_count !== 32'd2) begin
            errors++;
            $display("[TB] FAIL lw_use_count: got %0d expected 2", bus.stall_count);
        end
        bus.M_tnew = 2'd1; bus.D_tuse_rs = 2'd1;
        #1;
        checks++;
        if (bus.de_flush !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tnew_equals_tuse: got %0b expected 0", bus.de_flush);
        end
    endtask

    task automatic test_zero_and_nouse();
        do_reset();
        bus.E_wr = 5'd0; bus.D_rs = 5'd0; bus.E_tnew = 2'd2; bus.D_tuse_rs = 2'd0;
        #1;
        checks++;
        if (bus.de_flush !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_reg: got %0b expected 0", bus.de_flush);
        end
        bus.E_wr = 5'd9; bus.D_rt = 5'd9; bus.D_tuse_rt = 2'd3;
        #1;
        checks++;
        if (bus.pc_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tuse_3_no_stall: got %0b expected 1", bus.pc_en);
        end
        bus.D_tuse_rt = 2'd1;
        #1;
        checks++;
        if (bus.fd_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rt_hazard: got %0b expected 0", bus.fd_en);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.E_wr = 5'd7; bus.E_tnew = 2'd2;
        bus.D_rs = 5'd7; bus.D_tuse_rs = 2'd0;
        bus.D_rt = 5'd7; bus.D_tuse_rt = 2'd1;
        bus.D_is_md = 1'b1; bus.E_md_start = 1'b1; bus.E_md_is_div = 1'b0;
        tick();
        checks++;
        if (bus.stall_count !== 32'd1) begin
            errors++;
            $display("[TB] FAIL single_count_multi_hazard: got %0d expected 1", bus.stall_count);
        end
    endtask

    task automatic test_mult();
        int bad_left;
        int bad_stall;
        do_reset();
        bus.D_is_md = 1'b1; bus.E_md_start = 1'b1; bus.E_md_is_div = 1'b0;
        #1;
        checks++;
        if (bus.de_flush !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mult_immediate_stall: got %0b expected 1", bus.de_flush);
        end
        tick();
        bus.E_md_start = 1'b0;
        #1;
        bad_left  = 0;
        bad_stall = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.md_left !== 4'(5 - k)) bad_left++;
            if (bus.de_flush !== ((5 - k) != 0)) bad_stall++;
            if (k < 5) tick();
        end
        checks++;
        if (bad_left != 0) begin
            errors++;
            $display("[TB] FAIL mult_countdown: got %0d bad steps expected 0", bad_left);
        end
        checks++;
        if (bad_stall != 0) begin
            errors++;
            $display("[TB] FAIL mult_stall_window: got %0d bad steps expected 0", bad_stall);
        end
        checks++;
        if (bus.stall_count !== 32'd6) begin
            errors++;
            $display("[TB] FAIL mult_count: got %0d expected 6", bus.stall_count);
        end
        tick();
        checks++;
        if (bus.md_left !== 4'd0) begin
            errors++;
            $display("[TB] FAIL mult_hold_zero: got %0d expected 0", bus.md_left);
        end
    endtask

    task automatic test_div();
        int busy_cycles;
        int stall_seen;
        do_reset();
        bus.E_md_start = 1'b1; bus.E_md_is_div = 1'b1; bus.D_is_md = 1'b0;
        #1;
        checks++;
        if (bus.pc_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL div_no_md_in_d: got %0b expected 1", bus.pc_en);
        end
        tick();
        bus.E_md_start = 1'b0;
        checks++;
        if (bus.md_left !== 4'd10) begin
            errors++;
            $display("[TB] FAIL div_load: got %0d expected 10", bus.md_left);
        end
        busy_cycles = 0;
        stall_seen  = 0;
        for (int k = 0; k < 15; k++) begin
            #1;
            if (bus.md_busy === 1'b1) busy_cycles++;
            if (bus.de_flush !== 1'b0) stall_seen++;
            tick();
        end
        checks++;
        if (busy_cycles != 10) begin
            errors++;
            $display("[TB] FAIL div_busy_len: got %0d expected 10", busy_cycles);
        end
        checks++;
        if (stall_seen != 0 || bus.stall_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL div_no_stall: got %0d/%0d expected 0/0", stall_seen, bus.stall_count);
        end
    endtask

    task automatic test_restart();
        do_reset();
        bus.E_md_start = 1'b1; bus.E_md_is_div = 1'b0;
        tick();
        bus.E_md_start = 1'b0;
        tick();
        checks++;
        if (bus.md_left !== 4'd4) begin
            errors++;
            $display("[TB] FAIL restart_pre: got %0d expected 4", bus.md_left);
        end
        bus.E_md_start = 1'b1; bus.E_md_is_div = 1'b1;
        tick();
        bus.E_md_start = 1'b0;
        checks++;
        if (bus.md_left !== 4'd10) begin
            errors++;
            $display("[TB] FAIL restart_reload: got %0d expected 10", bus.md_left);
        end
    endtask

    task automatic test_reset_mid_div();
        do_reset();
        bus.D_is_md = 1'b1; bus.E_md_start = 1'b1; bus.E_md_is_div = 1'b1;
        tick();
        bus.E_md_start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (bus.md_left !== 4'd6 || bus.stall_count !== 32'd5) begin
            errors++;
            $display("[TB] FAIL mid_div_state: got left=%0d cnt=%0d expected left=6 cnt=5",
                     bus.md_left, bus.stall_count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.md_left !== 4'd0 || bus.md_busy !== 1'b0 || bus.stall_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL mid_div_reset: got left=%0d busy=%0b cnt=%0d expected 0/0/0",
                     bus.md_left, bus.md_busy, bus.stall_count);
        end
        bus.D_is_md = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        bus.E_wr = 5'd8; bus.E_tnew = 2'd2; bus.D_rs = 5'd8; bus.D_tuse_rs = 2'd0;
        for (int k = 0; k < 15; k++) tick();
        checks++;
        if (bus4.stall_count !== 4'd15) begin
            errors++;
            $display("[TB] FAIL sat_reach: got %0d expected 15", bus4.stall_count);
        end
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (bus4.stall_count !== 4'd15) begin
            errors++;
            $display("[TB] FAIL sat_hold: got %0d expected 15", bus4.stall_count);
        end
        checks++;
        if (bus.stall_count !== 32'd20) begin
            errors++;
            $display("[TB] FAIL wide_count: got %0d expected 20", bus.stall_count);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        clear_inputs();
        test_reset();
        test_lw_use();
        test_zero_and_nouse();
        test_back_to_back();
        test_mult();
        test_div();
        test_restart();
        test_reset_mid_div();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
